// File: rtl/polyeta_pack.sv
// ============================================================================
// polyeta_pack
// ----------------------------------------------------------------------------
// Packs one 256-coefficient polynomial whose coefficients lie in [-ETA,ETA]
// into the Dilithium polyeta byte encoding. Each packed value is ETA minus the
// coefficient, truncated to 4 bits (ETA=4) or 3 bits (ETA=2). Those values are
// laid out LSB-first in r_out. One coefficient group is handled per cycle:
//   ETA=4 : two coefficients -> one byte, 128 cycles
//   ETA=2 : eight coefficients -> three bytes, 32 cycles
//
// Parameters
//   ETA        coefficient bound, 2 or 4 only
//
// Ports
//   clock   in   1     rising-edge clock
//   reset   in   1     synchronous active-high reset
//   start   in   1     level request, sampled while waiting for work
//   a_in    in   8192  256 signed 32-bit coefficients, a[i] = a_in[32*i +: 32]
//   r_out   out  1024  packed bytes, byte k = r_out[8*k +: 8]
//   done    out  1     high while the finished result is being presented
//   err     out  1     sticky out-of-range flag (optional feature)
//
// Optional feature macro: POLYETA_PACK_RANGE_CHECK_EN
//   defined     : any coefficient outside [-ETA,ETA] seen while packing sets
//                 err, which stays set until the next pass starts or reset
//   not defined : err is tied low and no compare logic is built
// ============================================================================
module polyeta_pack #(
   parameter int ETA = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [8191:0] a_in,
   output logic [1023:0] r_out,
   output logic          done,
   output logic          err
);

   localparam int LAST_IDX = (ETA == 2) ? 31 : 127;

   generate
      if (ETA != 2 && ETA != 4) begin : g_bad_eta
         $error("polyeta_pack: ETA must be 2 or 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_INIT,
      S_PACK,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      idx_q, idx_d;
   logic [1023:0]   r_out_q, r_out_d;

`ifdef POLYETA_PACK_RANGE_CHECK_EN
   logic            err_q, err_d;
   logic signed [31:0] coef;
`else
   // Only the low bits of each coefficient reach the encoding; the upper
   // bits are folded here so they are consciously consumed.
   logic            unused_coef_hi;
   assign unused_coef_hi = ^a_in;
`endif

   logic [3:0]      t4;
   logic [2:0]      t2;

   // Sequential state: everything resets synchronously.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         r_out_q <= '0;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         r_out_q <= r_out_d;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Next-state and datapath. Only the low bits of ETA - a[i] are kept, and
   // low bits of a difference depend only on low bits of the operands, so the
   // narrow subtraction matches the 32-bit wrap-around result.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      r_out_d = r_out_q;
      t4      = '0;
      t2      = '0;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
      err_d   = err_q;
      coef    = '0;
`endif
      case (state_q)
         S_IDLE: begin
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (start) begin
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            idx_d   = '0;
            r_out_d = '0;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
            err_d   = 1'b0;
`endif
            state_d = S_PACK;
         end
         S_PACK: begin
            if (ETA == 4) begin
               for (int j = 0; j < 2; j++) begin
                  t4 = 4'd4 - a_in[64*int'(idx_q) + 32*j +: 4];
                  r_out_d[8*int'(idx_q) + 4*j +: 4] = t4;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
                  coef = a_in[64*int'(idx_q) + 32*j +: 32];
                  if (coef > 32'sd4 || coef < -32'sd4) begin
                     err_d = 1'b1;
                  end
`endif
               end
            end else begin
               for (int j = 0; j < 8; j++) begin
                  t2 = 3'd2 - a_in[256*int'(idx_q[4:0]) + 32*j +: 3];
                  r_out_d[24*int'(idx_q[4:0]) + 3*j +: 3] = t2;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
                  coef = a_in[256*int'(idx_q[4:0]) + 32*j +: 32];
                  if (coef > 32'sd2 || coef < -32'sd2) begin
                     err_d = 1'b1;
                  end
`endif
               end
            end
            if (int'(idx_q) == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         S_DONE: begin
            // A held start must not retrigger; wait for it to drop first.
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign r_out = r_out_q;
   assign done  = (state_q == S_DONE);
`ifdef POLYETA_PACK_RANGE_CHECK_EN
   assign err   = err_q;
`else
   assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_polyeta_pack.sv
// ============================================================================
// tb_polyeta_pack
// ----------------------------------------------------------------------------
// Drives one ETA=4 and one ETA=2 instance of polyeta_pack and compares their
// results against a bit-stream reference model of the polyeta encoding.
// ============================================================================
module tb_polyeta_pack;

   logic          clock = 1'b0;
   logic          reset;
   logic          start4, start2;
   logic [8191:0] a4, a2;
   logic [1023:0] r4, r2;
   logic          done4, done2, err4, err2;

   int err_count   = 0;
   int check_count = 0;

   // Free-running clock shared by both instances.
   always #5 clock = ~clock;

   polyeta_pack #(.ETA(4)) u_eta4 (
      .clock (clock),
      .reset (reset),
      .start (start4),
      .a_in  (a4),
      .r_out (r4),
      .done  (done4),
      .err   (err4)
   );

   polyeta_pack #(.ETA(2)) u_eta2 (
      .clock (clock),
      .reset (reset),
      .start (start2),
      .a_in  (a2),
      .r_out (r2),
      .done  (done2),
      .err   (err2)
   );

   // Reference encoding: t_i = eta - a_i in integer arithmetic, then each t_i
   // contributes its low 'bits' bits to a little-endian bit stream.
   function automatic logic [1023:0] model_bytes(input int eta, input logic [8191:0] a);
      logic [1023:0] r;
      int bits;
      int c;
      int t;
      r = '0;
      bits = (eta == 4) ? 4 : 3;
      for (int i = 0; i < 256; i++) begin
         c = $signed(a[32*i +: 32]);
         t = eta - c;
         for (int b = 0; b < bits; b++) begin
            r[bits*i + b] = t[b];
         end
      end
      return r;
   endfunction

   function automatic logic model_err(input int eta, input logic [8191:0] a);
      logic e;
      int c;
      e = 1'b0;
`ifdef POLYETA_PACK_RANGE_CHECK_EN
      for (int i = 0; i < 256; i++) begin
         c = $signed(a[32*i +: 32]);
         if (c > eta || c < -eta) e = 1'b1;
      end
`else
      c = 0;
      if (eta < c) e = 1'b0;
      if (a[0] === 1'bz) e = 1'b0;
`endif
      return e;
   endfunction

   function automatic logic [8191:0] vec_const(input int v);
      logic [8191:0] a;
      for (int i = 0; i < 256; i++) a[32*i +: 32] = 32'(v);
      return a;
   endfunction

   function automatic logic [8191:0] vec_rand(input int eta, input bit wild);
      logic [8191:0] a;
      for (int i = 0; i < 256; i++) begin
         if (wild && ($urandom_range(0, 3) == 0)) a[32*i +: 32] = $urandom;
         else a[32*i +: 32] = 32'(int'($urandom_range(0, 2*eta)) - eta);
      end
      return a;
   endfunction

   task automatic checkOutput(input string tag, input logic [1023:0] observed,
                              input logic [1023:0] expected);
      check_count++;
      if (observed !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Runs one full pass on the chosen instance, checks latency, bytes and
   // err, optionally holds start high in DONE, then returns to WAIT_START.
   task automatic applyStimulus(input int eta, input logic [8191:0] a,
                                input string tag, input int hold);
      logic [1023:0] exp_r;
      int cycles;
      bit seen;
      exp_r = model_bytes(eta, a);
      @(negedge clock);
      if (eta == 4) begin a4 = a; start4 = 1'b1; end
      else          begin a2 = a; start2 = 1'b1; end
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 400) begin
         @(negedge clock);
         cycles++;
         seen = (eta == 4) ? done4 : done2;
      end
      checkOutput({tag, " done"}, 1024'(seen), 1024'(1));
      checkOutput({tag, " latency"}, 1024'(cycles), 1024'((eta == 4) ? 130 : 34));
      checkOutput({tag, " r_out"}, (eta == 4) ? r4 : r2, exp_r);
      checkOutput({tag, " err"}, 1024'((eta == 4) ? err4 : err2), 1024'(model_err(eta, a)));
      if (hold > 0) begin
         repeat (hold) @(negedge clock);
         checkOutput({tag, " held done"}, 1024'((eta == 4) ? done4 : done2), 1024'(1));
         checkOutput({tag, " held r_out"}, (eta == 4) ? r4 : r2, exp_r);
      end
      if (eta == 4) start4 = 1'b0; else start2 = 1'b0;
      @(negedge clock);
      checkOutput({tag, " done drop"}, 1024'((eta == 4) ? done4 : done2), 1024'(0));
      checkOutput({tag, " r_out kept"}, (eta == 4) ? r4 : r2, exp_r);
      @(negedge clock);
   endtask

   initial begin
      logic [8191:0] a;
      reset  = 1'b1;
      start4 = 1'b0;
      start2 = 1'b0;
      a4     = '0;
      a2     = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset r4", r4, '0);
      checkOutput("reset done4", 1024'(done4), 1024'(0));
      checkOutput("reset err4", 1024'(err4), 1024'(0));
      checkOutput("reset r2", r2, '0);
      checkOutput("reset done2", 1024'(done2), 1024'(0));
      checkOutput("reset err2", 1024'(err2), 1024'(0));
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // ETA=4 directed vectors
      applyStimulus(4, vec_const(0), "e4 zero", 0);
      checkOutput("e4 zero byte0", 1024'(r4[7:0]), 1024'(8'h44));
      checkOutput("e4 zero byte127", 1024'(r4[1023:1016]), 1024'(8'h44));
      a = '0;
      for (int i = 0; i < 256; i++) a[32*i +: 32] = (i % 2 == 0) ? 32'd4 : -32'sd4;
      applyStimulus(4, a, "e4 alt", 0);
      checkOutput("e4 alt byte5", 1024'(r4[47:40]), 1024'(8'h80));
      applyStimulus(4, vec_const(-4), "e4 neg", 0);
      checkOutput("e4 neg byte9", 1024'(r4[79:72]), 1024'(8'h88));
      a = '0;
      a[32*5 +: 32] = 32'd5;
      applyStimulus(4, a, "e4 a5", 0);
      checkOutput("e4 a5 byte2", 1024'(r4[23:16]), 1024'(8'hF4));

      // ETA=4 random vectors, in range and with wild 32-bit values
      applyStimulus(4, vec_rand(4, 1'b0), "e4 rand0", 0);
      applyStimulus(4, vec_rand(4, 1'b0), "e4 rand1", 0);
      applyStimulus(4, vec_rand(4, 1'b1), "e4 wild", 0);

      // ETA=2 directed and random vectors
      applyStimulus(2, vec_const(0), "e2 zero", 0);
      checkOutput("e2 zero bytes0-2", 1024'(r2[23:0]), 1024'(24'h492492));
      checkOutput("e2 zero bytes93-95", 1024'(r2[767:744]), 1024'(24'h492492));
      checkOutput("e2 zero tail", 1024'(r2[1023:768]), 1024'(0));
      a = '0;
      for (int i = 0; i < 256; i++) a[32*i +: 32] = 32'(2 - (i % 8));
      applyStimulus(2, a, "e2 ramp", 0);
      checkOutput("e2 ramp bytes0-2", 1024'(r2[23:0]), 1024'(24'hFAC688));
      applyStimulus(2, vec_rand(2, 1'b0), "e2 rand", 0);
      applyStimulus(2, vec_rand(2, 1'b1), "e2 wild", 0);

      // Reset in the middle of an ETA=4 pass (idx=50), then a fresh pass
      // with start held high in DONE.
      @(negedge clock);
      a4 = vec_rand(4, 1'b0);
      start4 = 1'b1;
      repeat (52) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midreset r4", r4, '0);
      checkOutput("midreset done4", 1024'(done4), 1024'(0));
      reset = 1'b0;
      start4 = 1'b0;
      repeat (2) @(negedge clock);
      applyStimulus(4, vec_rand(4, 1'b0), "e4 after reset", 20);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
